song_recorder: RTL and testbench

Records a melody played on the push-button/switch inputs into the note memory that `song_reader` plays back, acting as the writer for that reader. Sits between the synchronized button/switch inputs and the write port of the shared song RAM. Paced by the slow-enable tick from `DIV256ISH`. Each stored entry is a note code and a duration in ticks. A terminator entry closes every recording.

---
 rtl/song_pkg.sv | 29 ++
 rtl/song_recorder_if.sv | 33 +++
 rtl/song_rec_tracker.sv | 67 ++++++
 rtl/song_recorder.sv | 166 ++++++++++++++++
 tb/tb_song_recorder.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/song_pkg.sv
// song_pkg -- definitions shared by song_recorder (writer) and song_reader (player).
// Holds the note/duration widths, the rest code, the {note, duration} entry
// packing and the terminator entry that closes every stored melody.
package song_pkg;

  localparam int NOTE_W  = 3;
  localparam int DUR_W   = 8;
  localparam int ENTRY_W = NOTE_W + DUR_W;

  typedef logic [NOTE_W-1:0]  note_t;
  typedef logic [DUR_W-1:0]   dur_t;
  typedef logic [ENTRY_W-1:0] entry_t;

  // Note code 0 is silence.
  localparam note_t REST = {NOTE_W{1'b0}};

  localparam dur_t DUR_ZERO = {DUR_W{1'b0}};
  localparam dur_t DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};
  localparam dur_t DUR_MAX  = {DUR_W{1'b1}};

  // Duration 0 is never used by a real note, so {REST, 0} marks end of song.
  localparam entry_t TERMINATOR = {ENTRY_W{1'b0}};

  // Single place that fixes the entry layout: note in the MSBs, duration below.
  function automatic entry_t pack_entry(input note_t note, input dur_t dur);
    return {note, dur};
  endfunction

endpackage

// File: rtl/song_recorder_if.sv
// song_recorder_if -- control inputs and RAM-write/status outputs of song_recorder.
//   tick, rec_start, rec_stop, key_down, note_sel : player side -> recorder
//   wr_en, wr_addr, wr_data                        : recorder -> song RAM write port
//   busy, full, len                                : recorder status
// master = the side driving the controls, slave = the recorder itself.
interface song_recorder_if #(
  parameter int ADDR_W = 5
);
  import song_pkg::*;

  logic              tick;
  logic              rec_start;
  logic              rec_stop;
  logic              key_down;
  note_t             note_sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  entry_t            wr_data;
  logic              busy;
  logic              full;
  logic [ADDR_W-1:0] len;

  modport master (
    output tick, rec_start, rec_stop, key_down, note_sel,
    input  wr_en, wr_addr, wr_data, busy, full, len
  );

  modport slave (
    input  tick, rec_start, rec_stop, key_down, note_sel,
    output wr_en, wr_addr, wr_data, busy, full, len
  );

endinterface

// File: rtl/song_rec_tracker.sv
// song_rec_tracker -- run-length tracker for the note currently being held.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   load_i     : start of recording; capture sym_i and clear the run
//   tick_i     : time quantum to account (already gated by the FSM)
//   sym_i      : symbol for this tick (note or REST)
//   emit_o     : this tick closes the current run; entry_o must be written
//   entry_o    : {cur_note, dur} of the current run
//   dur_nz_o   : a run is open (dur != 0)
module song_rec_tracker
  import song_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   tick_i,
  input  note_t  sym_i,
  output logic   emit_o,
  output entry_t entry_o,
  output logic   dur_nz_o
);

  note_t cur_note_q, cur_note_d;
  dur_t  dur_q, dur_d;

  // Run bookkeeping: open a run, close it on a note change or saturation, or extend it.
  always_comb begin
    cur_note_d = cur_note_q;
    dur_d      = dur_q;
    emit_o     = 1'b0;
    if (load_i) begin
      cur_note_d = sym_i;
      dur_d      = DUR_ZERO;
    end else if (tick_i) begin
      if (dur_q == DUR_ZERO) begin
        // First tick of a recording only opens the run.
        cur_note_d = sym_i;
        dur_d      = DUR_ONE;
      end else if ((sym_i != cur_note_q) || (dur_q == DUR_MAX)) begin
        // A saturated run is closed even if the note continues, so long
        // notes become several consecutive entries of the same note.
        emit_o     = 1'b1;
        cur_note_d = sym_i;
        dur_d      = DUR_ONE;
      end else begin
        dur_d = dur_q + DUR_ONE;
      end
    end else begin
      emit_o = 1'b0;
    end
  end

  // Run state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_note_q <= REST;
      dur_q      <= DUR_ZERO;
    end else begin
      cur_note_q <= cur_note_d;
      dur_q      <= dur_d;
    end
  end

  assign entry_o  = pack_entry(cur_note_q, dur_q);
  assign dur_nz_o = (dur_q != DUR_ZERO);

endmodule

// File: rtl/song_recorder.sv
// song_recorder -- records button/switch melodies into the song RAM as
// {note, duration} entries followed by a terminator.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : song_recorder_if.slave (controls in, RAM write strobe/address/data
//          and busy/full/len status out; all outputs registered)
// State meaning: FLUSH = an entry is on the write port and the terminator
// follows next cycle; TERM = the terminator is on the write port.
module song_recorder #(
  parameter int ADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  song_recorder_if.slave bus
);
  import song_pkg::*;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_TERM   = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ZERO      = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
  // Last address a note may use; the top address is kept for the terminator.
  localparam logic [ADDR_W-1:0] ADDR_LAST_NOTE = {{(ADDR_W-1){1'b1}}, 1'b0};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_pend_q, full_pend_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  entry_t            wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] len_q, len_d;

  note_t  sym_s;
  logic   trk_load_s;
  logic   trk_tick_s;
  logic   trk_emit_s;
  entry_t trk_entry_s;
  logic   trk_dur_nz_s;

  assign sym_s      = bus.key_down ? bus.note_sel : REST;
  assign trk_load_s = (state_q == S_IDLE) && bus.rec_start;
  // A stop discards a tick arriving in the same cycle.
  assign trk_tick_s = (state_q == S_RECORD) && bus.tick && !bus.rec_stop;

  song_rec_tracker u_tracker (
    .clk      (clk),
    .rst      (rst),
    .load_i   (trk_load_s),
    .tick_i   (trk_tick_s),
    .sym_i    (sym_s),
    .emit_o   (trk_emit_s),
    .entry_o  (trk_entry_s),
    .dur_nz_o (trk_dur_nz_s)
  );

  // Recording FSM: computes the next write and status values one cycle ahead.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    full_pend_d = full_pend_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    full_d      = full_q;
    len_d       = len_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rec_start) begin
          state_d     = S_RECORD;
          addr_d      = ADDR_ZERO;
          len_d       = ADDR_ZERO;
          full_d      = 1'b0;
          full_pend_d = 1'b0;
          wr_addr_d   = ADDR_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECORD: begin
        if (bus.rec_stop) begin
          if (trk_dur_nz_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = trk_entry_s;
            addr_d    = addr_q + ADDR_ONE;
            len_d     = len_q + ADDR_ONE;
            state_d   = S_FLUSH;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = TERMINATOR;
            state_d   = S_TERM;
          end
        end else if (trk_emit_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = trk_entry_s;
          addr_d    = addr_q + ADDR_ONE;
          len_d     = len_q + ADDR_ONE;
          if (addr_q == ADDR_LAST_NOTE) begin
            // Memory exhausted: only the terminator slot remains.
            state_d     = S_FLUSH;
            full_pend_d = 1'b1;
          end else begin
            state_d = S_RECORD;
          end
        end else begin
          state_d = S_RECORD;
        end
      end
      S_FLUSH: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = TERMINATOR;
        full_d    = full_pend_q;
        state_d   = S_TERM;
      end
      S_TERM: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, address counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= ADDR_ZERO;
      full_pend_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= ADDR_ZERO;
      wr_data_q   <= TERMINATOR;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      len_q       <= ADDR_ZERO;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      full_pend_q <= full_pend_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      full_q      <= full_d;
      len_q       <= len_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.full    = full_q;
  assign bus.len     = len_q;

endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder -- scoreboard bench for song_recorder.
// Stimulus pushes the expected RAM writes into a queue; a monitor on the
// falling edge pops and compares every write the recorder issues.
module tb_song_recorder;
  import song_pkg::*;

  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    entry_t            data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  song_recorder_if #(.ADDR_W(ADDR_W)) bus ();

  song_recorder #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (bus.wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        w = exp_q.pop_front();
        if ((bus.wr_addr !== w.addr) || (bus.wr_data !== w.data)) begin
          failures++;
          $display("FAIL ram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.wr_addr, bus.wr_data, w.addr, w.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int a, input int note, input int dur);
    wr_t w;
    w.addr = a[ADDR_W-1:0];
    w.data = pack_entry(note[NOTE_W-1:0], dur[DUR_W-1:0]);
    exp_q.push_back(w);
  endtask

  // One cycle with tick high; returns in the following cycle.
  task automatic tick_sym(input logic k, input int note);
    bus.tick     = 1'b1;
    bus.key_down = k;
    bus.note_sel = note[NOTE_W-1:0];
    step();
    bus.tick = 1'b0;
  endtask

  task automatic start_rec();
    bus.rec_start = 1'b1;
    step();
    bus.rec_start = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    chk("len_after_start", {27'd0, bus.len}, 32'd0);
  endtask

  // Called in the cycle after rec_stop; checks busy timing and final status.
  task automatic finish_checks(input bit flush, input int exp_len, input int exp_full);
    if (flush) begin
      step();
      chk("busy_during_term", {31'd0, bus.busy}, 32'd1);
    end else begin
      chk("busy_during_term", {31'd0, bus.busy}, 32'd1);
    end
    step();
    chk("busy_after_term", {31'd0, bus.busy}, 32'd0);
    chk("len_final", {27'd0, bus.len}, exp_len[31:0]);
    chk("full_final", {31'd0, bus.full}, exp_full[31:0]);
  endtask

  task automatic stop_rec(input bit flush, input int exp_len);
    bus.rec_stop = 1'b1;
    step();
    bus.rec_stop = 1'b0;
    finish_checks(flush, exp_len, 0);
  endtask

  initial begin
    bus.tick      = 1'b0;
    bus.rec_start = 1'b0;
    bus.rec_stop  = 1'b0;
    bus.key_down  = 1'b0;
    bus.note_sel  = 3'd0;
    rst           = 1'b0;
    repeat (3) step();
    chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data", {21'd0, bus.wr_data}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_len", {27'd0, bus.len}, 32'd0);
    rst = 1'b1;
    step();

    // Note 3 for 4 ticks, rest for 2 ticks, stop (ticks spaced by idle cycles).
    expect_wr(0, 3, 4);
    expect_wr(1, 0, 2);
    expect_wr(2, 0, 0);
    start_rec();
    for (int i = 0; i < 4; i++) begin tick_sym(1'b1, 3); step(); end
    for (int i = 0; i < 2; i++) begin tick_sym(1'b0, 3); step(); end
    stop_rec(1'b1, 2);
    chk("wr_addr_held", {27'd0, bus.wr_addr}, 32'd2);

    // 300 ticks of note 5 splits at DUR_MAX.
    expect_wr(0, 5, 255);
    expect_wr(1, 5, 45);
    expect_wr(2, 0, 0);
    start_rec();
    for (int i = 0; i < 300; i++) tick_sym(1'b1, 5);
    stop_rec(1'b1, 2);

    // Toggle every tick until memory fills.
    for (int k = 1; k <= 31; k++) expect_wr(k - 1, ((k % 2) == 1) ? 1 : 2, 1);
    expect_wr(31, 0, 0);
    start_rec();
    for (int k = 1; k <= 32; k++) tick_sym(1'b1, ((k % 2) == 1) ? 1 : 2);
    chk("full_at_last_note", {31'd0, bus.full}, 32'd0);
    step();
    chk("full_at_term", {31'd0, bus.full}, 32'd1);
    chk("term_addr_top", {27'd0, bus.wr_addr}, 32'd31);
    step();
    chk("busy_after_full", {31'd0, bus.busy}, 32'd0);
    chk("len_full", {27'd0, bus.len}, 32'd31);
    bus.rec_stop = 1'b1;
    step();
    bus.rec_stop = 1'b0;
    repeat (3) step();
    chk("busy_late_stop", {31'd0, bus.busy}, 32'd0);
    chk("full_late_stop", {31'd0, bus.full}, 32'd1);
    chk("len_late_stop", {27'd0, bus.len}, 32'd31);

    // Stop coincides with a note-changing tick: tick discarded.
    expect_wr(0, 6, 3);
    expect_wr(1, 0, 0);
    start_rec();
    for (int i = 0; i < 3; i++) tick_sym(1'b1, 6);
    bus.tick     = 1'b1;
    bus.key_down = 1'b0;
    bus.rec_stop = 1'b1;
    step();
    bus.tick     = 1'b0;
    bus.rec_stop = 1'b0;
    finish_checks(1'b1, 1, 0);

    // Stop before any tick: terminator only.
    expect_wr(0, 0, 0);
    start_rec();
    stop_rec(1'b0, 0);

    // Start and stop together in IDLE: recording starts, stop ignored.
    expect_wr(0, 0, 0);
    bus.rec_start = 1'b1;
    bus.rec_stop  = 1'b1;
    step();
    bus.rec_start = 1'b0;
    bus.rec_stop  = 1'b0;
    chk("busy_start_stop_same", {31'd0, bus.busy}, 32'd1);
    step();
    chk("still_busy_no_write", {31'd0, bus.busy}, 32'd1);
    stop_rec(1'b0, 0);

    // Reset in the middle of a run with dur=7.
    start_rec();
    for (int i = 0; i < 7; i++) tick_sym(1'b1, 2);
    rst = 1'b0;
    step();
    chk("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("midrst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
    chk("midrst_wr_data", {21'd0, bus.wr_data}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_full", {31'd0, bus.full}, 32'd0);
    chk("midrst_len", {27'd0, bus.len}, 32'd0);
    rst = 1'b1;
    step();
    chk("idle_after_rst", {31'd0, bus.busy}, 32'd0);
    expect_wr(0, 4, 2);
    expect_wr(1, 0, 0);
    start_rec();
    for (int i = 0; i < 2; i++) tick_sym(1'b1, 4);
    stop_rec(1'b1, 1);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
